// File: rtl/tdc_sched_pkg.sv
// Shared types and constants for the TDC readout scheduler.
// One-hot FSM encoding, state bit positions and index-width helper.
package tdc_sched_pkg;

  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_ARB_BIT   = 1;
  localparam int ST_SERVE_BIT = 2;
  localparam int ST_DONE_BIT  = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ARB   = 4'b0010,
    ST_SERVE = 4'b0100,
    ST_DONE  = 4'b1000
  } sched_state_e;

  // Upper byte of a TDC trailer word.
  localparam logic [7:0] TRAILER_FILL = 8'hF0;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating-priority encoder: picks the first requester strictly after last_idx,
// wrapping modulo N. Purely combinational.
module rr_priority_select
  import tdc_sched_pkg::*;
#(
  parameter int N  = 10,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_idx_i,
  output logic [N-1:0]  winner_o,
  output logic [IW-1:0] winner_idx_o
);

  logic [IW-1:0] cand_s;

  // Scan from farthest to nearest so the nearest requester after last_idx wins.
  always_comb begin
    winner_o     = {N{1'b0}};
    winner_idx_o = {IW{1'b0}};
    cand_s       = {IW{1'b0}};
    for (int k = N; k >= 1; k--) begin
      cand_s = IW'((int'(last_idx_i) + k) % N);
      if (req_i[cand_s]) begin
        winner_o         = {N{1'b0}};
        winner_o[cand_s] = 1'b1;
        winner_idx_o     = cand_s;
      end
    end
  end

endmodule

// File: rtl/tdc_readout_scheduler.sv
// Round-robin grant of locked TDC FIFOs to the event builder, one TDC at a time
// until its trailer is popped. Optional event watchdog: define SCHED_TIMEOUT_EN.
module tdc_readout_scheduler
  import tdc_sched_pkg::*;
#(
  parameter int TDC_COUNT      = 10,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [TDC_COUNT-1:0] locked_array_i,
  input  logic [TDC_COUNT-1:0] tdc_fifo_empty_array_i,
  input  logic                 pop_i,
  input  logic                 pop_is_trailer_i,
  output logic [TDC_COUNT-1:0] grant_o,
  output logic                 grant_valid_o,
  output logic                 done_o,
  output logic [TDC_COUNT-1:0] timeout_array_o,
  output logic                 busy_o
);

  localparam int IW = idx_width(TDC_COUNT);

  sched_state_e         state_q, state_d;
  logic [TDC_COUNT-1:0] pending_q, pending_d;
  logic [TDC_COUNT-1:0] grant_q, grant_d;
  logic [IW-1:0]        last_idx_q, last_idx_d;

  logic [TDC_COUNT-1:0] req_s, win_s;
  logic [IW-1:0]        win_idx_s;
  logic                 active_s, trailer_s, expire_s;

  assign req_s    = pending_q & ~tdc_fifo_empty_array_i;
  assign active_s = state_q[ST_ARB_BIT] | state_q[ST_SERVE_BIT];

  rr_priority_select #(
    .N  (TDC_COUNT),
    .IW (IW)
  ) u_rr_sel (
    .req_i        (req_s),
    .last_idx_i   (last_idx_q),
    .winner_o     (win_s),
    .winner_idx_o (win_idx_s)
  );

  assign grant_o       = grant_q;
  assign grant_valid_o = state_q[ST_SERVE_BIT] & (|(grant_q & ~tdc_fifo_empty_array_i));
  assign done_o        = state_q[ST_DONE_BIT];
  assign busy_o        = ~state_q[ST_IDLE_BIT];

  // A pop is honoured only while the builder was actually allowed to pop.
  assign trailer_s = grant_valid_o & pop_i & pop_is_trailer_i;

`ifdef SCHED_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [TDC_COUNT-1:0]     timeout_q, timeout_d;

  assign expire_s        = active_s & (timer_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign timeout_array_o = timeout_q;

  // Event timer: cleared on start, saturating count while arbitrating or serving.
  always_comb begin
    timer_d = timer_q;
    if (state_q[ST_IDLE_BIT] && start_i) begin
      timer_d = {TIMEOUT_WIDTH{1'b0}};
    end else if (active_s && !(&timer_q)) begin
      timer_d = timer_q + TIMEOUT_WIDTH'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // A trailer landing on the expiry cycle retires its TDC before flagging.
  always_comb begin
    timeout_d = timeout_q;
    if (state_q[ST_IDLE_BIT] && start_i) begin
      timeout_d = {TDC_COUNT{1'b0}};
    end else if (expire_s) begin
      timeout_d = trailer_s ? (pending_q & ~grant_q) : pending_q;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= {TIMEOUT_WIDTH{1'b0}};
      timeout_q <= {TDC_COUNT{1'b0}};
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign expire_s        = 1'b0;
  assign timeout_array_o = {TDC_COUNT{1'b0}};
`endif

  // Next-state logic for arbitration and grant hold.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    grant_d    = grant_q;
    last_idx_d = last_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pending_d = locked_array_i;
          state_d   = ST_ARB;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (expire_s || (pending_q == {TDC_COUNT{1'b0}})) begin
          state_d = ST_DONE;
        end else if (|req_s) begin
          grant_d    = win_s;
          last_idx_d = win_idx_s;
          state_d    = ST_SERVE;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_SERVE: begin
        if (trailer_s) begin
          pending_d = pending_q & ~grant_q;
          grant_d   = {TDC_COUNT{1'b0}};
        end else begin
          pending_d = pending_q;
        end
        if (expire_s) begin
          grant_d = {TDC_COUNT{1'b0}};
          state_d = ST_DONE;
        end else if (trailer_s) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_DONE: begin
        grant_d = {TDC_COUNT{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = {TDC_COUNT{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pending set, grant and fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= {TDC_COUNT{1'b0}};
      grant_q    <= {TDC_COUNT{1'b0}};
      last_idx_q <= IW'(TDC_COUNT - 1);
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_tdc_readout_scheduler.sv
// Randomized self-checking bench for tdc_readout_scheduler with a queue/array
// FIFO model and a round-robin reference derived from the scheduling rules.
module tb_tdc_readout_scheduler;

  localparam int N  = 10;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [N-1:0] locked_i;
  logic [N-1:0] empty_i;
  logic         pop_i;
  logic         trl_i;
  logic [N-1:0] grant_o;
  logic         gv_o;
  logic         done_o;
  logic [N-1:0] timeout_o;
  logic         busy_o;

  int total = 0;
  int bad   = 0;
  int cnt[N];
  int avail[N];
  int cyc;
  int last_m;
  bit stall;
  int order[$];

  always #5 clk = ~clk;

  tdc_readout_scheduler #(
    .TDC_COUNT      (N),
    .TIMEOUT_WIDTH  (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start_i                (start_i),
    .locked_array_i         (locked_i),
    .tdc_fifo_empty_array_i (empty_i),
    .pop_i                  (pop_i),
    .pop_is_trailer_i       (trl_i),
    .grant_o                (grant_o),
    .grant_valid_o          (gv_o),
    .done_o                 (done_o),
    .timeout_array_o        (timeout_o),
    .busy_o                 (busy_o)
  );

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First requester after 'last', wrapping around; -1 if none.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] cur_empty();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = (cnt[i] == 0) || (cyc < avail[i]) || (stall && grant_o[i]);
    return e;
  endfunction

  task automatic set_fifos(input int words);
    for (int i = 0; i < N; i++) begin cnt[i] = words; avail[i] = 0; end
    stall = 0; cyc = 0; empty_i = cur_empty();
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_m = N - 1;
  endtask

  task automatic run_event(input logic [N-1:0] locked, input int pop_pct, input bit rnd_stall, input int budget);
    logic [N-1:0] pend, arb_empty, prev_grant;
    int age, cur_g, g, dones;
    bit was_trl, fin, exp_done, exp_busy, exp_gv;
    pend = locked; age = -1; cur_g = -1; dones = 0; was_trl = 0; fin = 0; prev_grant = '0;
    order.delete();
    @(posedge clk); #1 start_i = 1'b1; locked_i = locked;
    @(posedge clk); #1 start_i = 1'b0; cyc = 0; stall = 0;
    if (pend == '0) age = 0;
    empty_i = cur_empty(); arb_empty = empty_i;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      exp_done = (pend == '0) && (age == 1);
      exp_busy = !((pend == '0) && (age >= 2));
      total += 3;
      if (done_o !== exp_done) begin bad++; $display("FAIL done c=%0d got=%b exp=%b", c, done_o, exp_done); end
      if (busy_o !== exp_busy) begin bad++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy_o, exp_busy); end
      if (timeout_o !== '0) begin bad++; $display("FAIL timeout_idle c=%0d got=%b exp=0", c, timeout_o); end
      if (done_o) dones++;
      total++;
      if (was_trl) begin
        if (grant_o !== '0) begin bad++; $display("FAIL grant_clear c=%0d got=%b exp=0", c, grant_o); end
      end else if (prev_grant == '0 && grant_o != '0) begin
        g = rr_pick(pend & ~arb_empty, last_m);
        if (g < 0 || grant_o !== onehot(g)) begin
          bad++; $display("FAIL grant_pick c=%0d got=%b exp_idx=%0d", c, grant_o, g);
        end else begin
          cur_g = g; last_m = g; order.push_back(g);
        end
      end else if (grant_o !== prev_grant) begin
        bad++; $display("FAIL grant_hold c=%0d got=%b exp=%b", c, grant_o, prev_grant);
      end
      exp_gv = (cur_g >= 0) && !empty_i[cur_g];
      total++;
      if (gv_o !== exp_gv) begin bad++; $display("FAIL grant_valid c=%0d got=%b exp=%b", c, gv_o, exp_gv); end
      prev_grant = grant_o; arb_empty = empty_i;
      if (exp_gv && ($urandom_range(99) < pop_pct)) begin pop_i = 1'b1; trl_i = (cnt[cur_g] == 1); end
      @(posedge clk); #1;
      was_trl = 0;
      if (pop_i) begin
        cnt[cur_g]--;
        if (trl_i) begin pend[cur_g] = 1'b0; cur_g = -1; was_trl = 1; end
      end
      pop_i = 1'b0; trl_i = 1'b0;
      if (pend == '0) age = (age < 0) ? 0 : age + 1;
      if (age >= 3) fin = 1;
      cyc++;
      stall = rnd_stall && ($urandom_range(7) == 0);
      empty_i = cur_empty();
    end
    stall = 0; empty_i = cur_empty();
    total += 2;
    if (!fin) begin bad++; $display("FAIL event_budget got=unfinished exp=done within %0d", budget); end
    if (dones != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; locked_i = '0; pop_i = 1'b0; trl_i = 1'b0;
    set_fifos(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 5;
    if (grant_o !== '0)   begin bad++; $display("FAIL rst_grant got=%b exp=0", grant_o); end
    if (gv_o !== 1'b0)    begin bad++; $display("FAIL rst_gv got=%b exp=0", gv_o); end
    if (done_o !== 1'b0)  begin bad++; $display("FAIL rst_done got=%b exp=0", done_o); end
    if (timeout_o !== '0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout_o); end
    if (busy_o !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    @(posedge clk); #1 rst = 1'b0;
    last_m = N - 1;
  endtask

  task automatic test_all_locked();
    bit ok;
    set_fifos(3);
    run_event(10'h3FF, 100, 1'b0, 400);
    ok = (order.size() == 10);
    for (int i = 0; i < order.size() && i < 10; i++) if (order[i] != i) ok = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL all_order got_size=%0d exp=TDC0..TDC9", order.size()); end
    set_fifos(3);
    run_event(10'h3FF, 100, 1'b0, 400);
    total++;
    if (order.size() == 0 || order[0] != 0) begin bad++; $display("FAIL second_first got=%0d exp=0", (order.size() != 0) ? order[0] : -1); end
  endtask

  task automatic test_rotation();
    set_fifos(2);
    run_event(10'h01F, 100, 1'b0, 300);
    total++;
    if (order.size() == 0 || order[order.size()-1] != 4) begin bad++; $display("FAIL rot_last got_size=%0d exp_last=4", order.size()); end
    set_fifos(2);
    run_event(10'h3FF, 100, 1'b0, 400);
    total++;
    if (order.size() == 0 || order[0] != 5) begin bad++; $display("FAIL rot_first got=%0d exp=5", (order.size() != 0) ? order[0] : -1); end
  endtask

  task automatic test_empty_holdoff();
    set_fifos(0);
    cnt[0] = 3; cnt[2] = 3; avail[0] = 20;
    empty_i = cur_empty();
    run_event(10'h005, 100, 1'b0, 300);
    total++;
    if (order.size() != 2 || order[0] != 2 || order[1] != 0) begin
      bad++; $display("FAIL holdoff_order got_size=%0d exp=TDC2,TDC0", order.size());
    end
  endtask

  task automatic test_no_locked();
    set_fifos(3);
    run_event(10'h000, 100, 1'b0, 20);
    total++;
    if (order.size() != 0) begin bad++; $display("FAIL nolock_grants got=%0d exp=0", order.size()); end
  endtask

  task automatic test_random();
    logic [N-1:0] lk;
    for (int e = 0; e < 10; e++) begin
      lk = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        cnt[i]   = $urandom_range(1, 2);
        avail[i] = ($urandom_range(1) == 0) ? 0 : $urandom_range(0, 15);
      end
      cyc = 0; stall = 0; empty_i = cur_empty();
      run_event(lk, 90, 1'b1, 1000);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_fifos(3);
    @(posedge clk); #1 start_i = 1'b1; locked_i = 10'h3FF;
    @(posedge clk); #1 start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (grant_o != '0) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL midrst_grant_seen got=none exp=grant"); end
    pulse_rst();
    @(negedge clk);
    total += 3;
    if (grant_o !== '0)  begin bad++; $display("FAIL midrst_grant got=%b exp=0", grant_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    if (gv_o !== 1'b0)   begin bad++; $display("FAIL midrst_gv got=%b exp=0", gv_o); end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (done_o !== 1'b0) begin bad++; $display("FAIL midrst_done c=%0d got=%b exp=0", c, done_o); end
      @(negedge clk);
    end
    set_fifos(3);
    run_event(10'h3FF, 100, 1'b0, 400);
    total++;
    if (order.size() == 0 || order[0] != 0) begin bad++; $display("FAIL midrst_first got=%0d exp=0", (order.size() != 0) ? order[0] : -1); end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic run_timeout(input logic [N-1:0] locked, input bit trl_at_expiry);
    int g;
    logic [N-1:0] exp_to;
    set_fifos(0);
    for (int i = 0; i < N; i++) if (locked[i]) cnt[i] = 1000;
    empty_i = cur_empty();
    g = rr_pick(locked & ~empty_i, last_m);
    exp_to = trl_at_expiry ? (locked & ~onehot(g)) : locked;
    @(posedge clk); #1 start_i = 1'b1; locked_i = locked;
    @(posedge clk); #1 start_i = 1'b0;
    for (int k = 0; k <= 103; k++) begin
      @(negedge clk);
      total++;
      if (done_o !== (k == 100)) begin bad++; $display("FAIL to_done k=%0d got=%b exp=%b", k, done_o, (k == 100)); end
      if (k == 0) begin
        total++;
        if (timeout_o !== '0) begin bad++; $display("FAIL to_clear got=%b exp=0", timeout_o); end
      end
      if (k == 1) begin
        total++;
        if (grant_o !== onehot(g)) begin bad++; $display("FAIL to_grant got=%b exp=%b", grant_o, onehot(g)); end
      end
      if (k == 100 || k == 103) begin
        total++;
        if (timeout_o !== exp_to) begin bad++; $display("FAIL to_array k=%0d got=%b exp=%b", k, timeout_o, exp_to); end
      end
      if (k == 102) begin
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL to_busy got=%b exp=0", busy_o); end
      end
      if (gv_o && k < 100) begin pop_i = 1'b1; trl_i = trl_at_expiry && (k == 99); end
      @(posedge clk); #1 pop_i = 1'b0; trl_i = 1'b0;
    end
    last_m = g;
    set_fifos(0);
  endtask

  task automatic test_timeout();
    run_timeout(10'b0000001000, 1'b0);
    run_timeout(10'b0001100000, 1'b1);
  endtask
`else
  task automatic test_wait_forever();
    set_fifos(0);
    cnt[3] = 1000;
    empty_i = cur_empty();
    @(posedge clk); #1 start_i = 1'b1; locked_i = 10'b0000001000;
    @(posedge clk); #1 start_i = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      total += 2;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL wait_hold k=%0d got_done=%b got_busy=%b exp=0/1", k, done_o, busy_o); end
      if (timeout_o !== '0) begin bad++; $display("FAIL wait_timeout k=%0d got=%b exp=0", k, timeout_o); end
      if (gv_o) pop_i = 1'b1;
      @(posedge clk); #1 pop_i = 1'b0;
    end
    pulse_rst();
    set_fifos(0);
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_locked();
    test_rotation();
    test_empty_holdoff();
    test_no_locked();
    test_random();
    test_reset_mid();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_readout_scheduler.md
# tdc_readout_scheduler

Round-robin scheduler that shares the per-TDC hit FIFOs with the trigger-mode event builder. For each triggered event it grants exactly one locked TDC FIFO at a time and holds that grant until the TDC's trailer is consumed, so each TDC's header, hits and trailer stay contiguous in the built event. An optional event watchdog closes the event when a TDC never delivers its trailer. It sits between the TDC FIFO array and the event builder's readout mux, replacing the builder's fixed-priority select.

## Interface
- TDC_COUNT, 10, number of TDC FIFOs (2..16)
- TIMEOUT_WIDTH, 16, width of the event watchdog counter
- TIMEOUT_CYCLES, 4000, cycles allowed per event from `start` to done (1..2^TIMEOUT_WIDTH-1)

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  one-cycle pulse from the builder when a trigger is taken
- locked_array  in  TDC_COUNT  TDCs participating in the event, sampled on `start`
- tdc_fifo_empty_array  in  TDC_COUNT  FIFO empty flags
- pop  in  1  builder consumed one word from the granted FIFO
- pop_is_trailer  in  1  the consumed word is a trailer (bits[31:24]=8'hF0); qualified by `pop`
- grant  out  TDC_COUNT  one-hot select of the granted FIFO; all zeros when nothing is granted
- grant_valid  out  1  `grant` is non-zero and the granted FIFO is not empty; builder may pop
- done  out  1  one-cycle pulse when the event is complete
- timeout_array  out  TDC_COUNT  TDCs still pending at watchdog expiry; held until next `start`
- busy  out  1  high in every state except IDLE

## Operation
- States are one-hot: IDLE, ARB, SERVE, DONE.
- IDLE:
  - On `start`: pending <= locked_array, timer <= 0, timeout_array <= 0, next state ARB.
  - `start` in any other state is ignored.
- ARB:
  - If pending is 0: go to DONE.
  - Otherwise, if any bit of pending & ~empty is set: register grant to the first such index searching from last_idx+1 upward, modulo TDC_COUNT. Set last_idx to that index and go to SERVE.
  - Otherwise stay in ARB.
- SERVE:
  - Grant is held.
  - On `pop` && `pop_is_trailer`: clear the granted pending bit, clear grant, go to ARB.
  - `pop` without trailer: stay in SERVE.
  - `pop` while grant_valid=0 is a protocol error and is ignored.
- DONE: assert `done` for one cycle, clear grant, go to IDLE.
- The timer increments every cycle in ARB and SERVE and saturates at all ones.
- last_idx persists across events, so fairness rotates between events too.
- grant_valid = SERVE & |(grant & ~tdc_fifo_empty_array). This is combinational from the registered grant.

## Timing
- Reset values: grant=0, grant_valid=0, done=0, timeout_array=0, busy=0, state=IDLE, last_idx=TDC_COUNT-1 (TDC0 is the first winner).
- Latencies:
  - `start` -> ARB: next cycle.
  - ARB -> grant visible: next cycle.
  - Trailer pop -> grant cleared: next cycle.
  - Minimum of 2 cycles per TDC switch.
- The empty flag of the granted FIFO may toggle during SERVE; grant_valid follows it combinationally.
- Reset mid-event returns everything to reset values on the next edge. No `done` pulse is issued.
- With locked_array=0: `start`, ARB, DONE. `done` is asserted 2 cycles after `start`.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - When the timer equals TIMEOUT_CYCLES-1 in ARB or SERVE: timeout_array <= remaining pending, state goes to DONE.
  - If a trailer pop coincides with expiry, that TDC's pending bit is cleared first and it is not flagged.
- Not defined:
  - No timer logic is built.
  - timeout_array is tied to 0.
  - The scheduler waits indefinitely for trailers.

## Structure
- Package `tdc_sched_pkg`:
  - state localparams and state bit indices
  - `clog2`-based index width function
  - trailer fill constant 8'hF0
- Sub-module `rr_priority_select`: combinational rotating-priority encoder. Inputs: request vector and last_idx. Outputs: one-hot winner and binary index.
- All sequential logic lives in `tdc_readout_scheduler`.

## Test plan
- locked=10'h3FF, all FIFOs non-empty, each with 3 words ending in a trailer -> grants TDC0..TDC9 in order, 30 pops, `done` asserted once, timeout_array=0.
- Second event, same setup, after the first ended on TDC9 -> first grant is TDC0. Make TDC4 the last winner -> next event starts at TDC5.
- locked=10'b0000000101, TDC0 empty for 20 cycles -> TDC2 granted first, then TDC0 once it is non-empty.
- `SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=100, TDC3 never sends a trailer -> `done` asserted 100 cycles after ARB entry, timeout_array=10'b0000001000.
- Trailer pop on the expiry cycle -> that TDC is absent from timeout_array.
- rst asserted during SERVE -> next cycle grant=0, busy=0, no `done`. A subsequent `start` grants TDC0.
